regfile_write_sequencer: RTL and testbench
==========================================

// Module: regfile_write_sequencer
// PURPOSE
//  Serialises the two register-write requests produced by write-back each cycle onto the
//  register file's single write port. Requests are buffered in a small in-order queue and drained
//  one per cycle. Back-pressure goes to write-back when the queue cannot take a full pair.
//  A read-side query port reports pending (not yet committed) writes so decode can forward or stall.
// PARAMETERS
//  DEPTH   4   queue entries; power of two, >= 2
//  DATA_W  32  register value width
//  REG_W   4   register index width
// PORTS
//  clock      in   1       single clock; all state updates on posedge
//  reset      in   1       asynchronous, active-high; clears all state immediately
//  wbValid    in   1       write-back presents a request pair this cycle
//  wbReady    out  1       sequencer accepts pair this cycle (valid && ready = accept)
//  wbWrite1   in   1       first write enable
//  wbReg1     in   REG_W   first write register index
//  wbValue1   in   DATA_W  first write value
//  wbWrite2   in   1       second write enable
//  wbReg2     in   REG_W   second write register index
//  wbValue2   in   DATA_W  second write value
//  rfWrite    out  1       register file write enable (registered)
//  rfReg      out  REG_W   register file write index (registered)
//  rfValue    out  DATA_W  register file write data (registered)
//  qReg       in   REG_W   query register index from decode
//  qPending   out  1       a write to qReg is queued or on the rf port this cycle
//  qValue     out  DATA_W  value of the youngest pending write to qReg; 0 when !qPending
// BEHAVIOUR
//  - Reset: queue empty (count=0, head=tail=0), rfWrite=0, rfReg=0, rfValue=0; wbReady=1,
//    qPending=0, qValue=0. Reset mid-operation discards every queued and in-flight entry.
//  - wbReady = (count <= DEPTH-2), combinational from count only; never depends on wbValid.
//  - On accept: enqueue write1 (if wbWrite1) then write2 (if wbWrite2), in that order.
//    An enable with register index REG_NONE (4'hF) is dropped and enqueues nothing.
//    0, 1 or 2 entries per accept. Without accept, the wb* inputs are ignored.
//  - Drain: each cycle with count>0 (count before this edge's enqueue), pop head into
//    rfWrite/rfReg/rfValue at the edge. Otherwise rfWrite<=0; rfReg/rfValue hold.
//  - Latency: an entry accepted at edge N is driven on the rf port no earlier than after edge N+1.
//    The register file commits it at the following edge. No bypass from wb inputs to rf port.
//  - Simultaneous enqueue(2)+dequeue(1): net count +1. Pointers wrap modulo DEPTH.
//  - Ordering strictly FIFO. Two writes to the same register (also within one pair) commit in
//    order, so write2 wins.
//  - count never exceeds DEPTH: wbReady gating guarantees room for 2. count is width clog2(DEPTH)+1.
//  - Query (combinational): search the rf-port entry (if rfWrite) plus all valid queue entries.
//    qPending=1 on any index match. qValue = value of the youngest match (queue tail side is
//    youngest, rf-port entry oldest). qReg=REG_NONE always gives qPending=0.
// STRUCTURE
//  - Shared package y86_pkg: REG_NONE=4'hF, register index constants, and a typedef
//    rf_write_t {reg[REG_W], value[DATA_W]} for queue entries.
//  - One sub-module: regwrite_fifo (DEPTH-entry circular buffer). It has a 0/1/2-entry push port,
//    a 1-entry pop, count, and a flat entry-valid/entry-data view for the query search.
//  - Top-level holds rf output registers, wbReady logic and the youngest-match priority search.
// TESTING
//  - Reset then idle: rfWrite=0, wbReady=1, qPending=0 for 10 cycles. Assert reset mid-burst
//    with 3 entries queued -> next cycle count=0, rfWrite=0.
//  - Single write (wbWrite1, r2, 0x11): accepted edge N; rfWrite=1,rfReg=2,rfValue=0x11 after
//    edge N+1 only; rfWrite=0 after N+2.
//  - Pair (r6=0x100, r3=0xAB) every cycle: rf sequence r6,r3,r6,r3... with no gaps. wbReady drops
//    when count reaches 3, and no request is lost or duplicated.
//  - Same-register pair (r1=5, r1=9): rf port shows 5 then 9. qReg=1 gives qValue=9 while both
//    are pending, and 9 after the first commits.
//  - REG_NONE: write1 to r15, write2 to r0=7 -> only one entry queued. qReg=15 gives qPending=0.
//  - Wrap: push/pop 3*DEPTH mixed 0/1/2-entry pairs against a reference queue model. rf order
//    and the query results match the model every cycle.

Source files
------------

// File: rtl/regfile_write_sequencer_pkg.sv
// Shared Y86 definitions: register indices, the "no register" marker and the queued write entry.
package y86_pkg;

    localparam int QUEUE_DEPTH = 4;
    localparam int DATA_W      = 32;
    localparam int REG_W       = 4;

    localparam logic [REG_W-1:0] REG_RAX  = 4'h0;
    localparam logic [REG_W-1:0] REG_RCX  = 4'h1;
    localparam logic [REG_W-1:0] REG_RDX  = 4'h2;
    localparam logic [REG_W-1:0] REG_RBX  = 4'h3;
    localparam logic [REG_W-1:0] REG_RSP  = 4'h4;
    localparam logic [REG_W-1:0] REG_RBP  = 4'h5;
    localparam logic [REG_W-1:0] REG_RSI  = 4'h6;
    localparam logic [REG_W-1:0] REG_RDI  = 4'h7;
    localparam logic [REG_W-1:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic [REG_W-1:0]  idx;
        logic [DATA_W-1:0] value;
    } rf_write_t;

endpackage

// File: rtl/regfile_write_sequencer_regwrite_fifo.sv
// In-order circular buffer of pending register writes: 0/1/2 pushes and at most one pop per cycle.
module regwrite_fifo
    import y86_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_push1,
    input  logic [REG_W+DATA_W-1:0]          i_push1_data,
    input  logic                             i_push2,
    input  logic [REG_W+DATA_W-1:0]          i_push2_data,
    input  logic                             i_pop,
    output logic [REG_W+DATA_W-1:0]          o_head,
    output logic [$clog2(DEPTH):0]           o_count,
    output logic [DEPTH-1:0]                 o_entry_valid,
    output logic [DEPTH*(REG_W+DATA_W)-1:0]  o_entry_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = REG_W + DATA_W;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    rf_write_t     r_mem [DEPTH];
    logic [1:0]    w_n_push;

    assign w_n_push = {1'b0, i_push1} + {1'b0, i_push2};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(i_pop);
            r_tail  <= r_tail + PW'(w_n_push);
            r_count <= r_count + CW'(w_n_push) - CW'(i_pop);
        end
    end

    // A lone write2 lands at the tail; after a write1 it goes one slot further.
    always_ff @(posedge i_clk) begin
        if (i_push1) r_mem[r_tail] <= i_push1_data;
        if (i_push2) r_mem[r_tail + PW'(i_push1)] <= i_push2_data;
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

    // Entry k of the view is the k-th oldest queued write.
    always_comb begin
        o_entry_valid = '0;
        o_entry_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            o_entry_valid[k]          = CW'(k) < r_count;
            o_entry_data[k*EW +: EW]  = r_mem[r_head + PW'(k)];
        end
    end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Funnels write-back's two register writes per cycle onto the single register-file write port,
// and answers decode's "is a write to this register still pending?" query.
module regfile_write_sequencer
    import y86_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_wbValid,
    output logic              o_wbReady,
    input  logic              i_wbWrite1,
    input  logic [REG_W-1:0]  i_wbReg1,
    input  logic [DATA_W-1:0] i_wbValue1,
    input  logic              i_wbWrite2,
    input  logic [REG_W-1:0]  i_wbReg2,
    input  logic [DATA_W-1:0] i_wbValue2,
    output logic              o_rfWrite,
    output logic [REG_W-1:0]  o_rfReg,
    output logic [DATA_W-1:0] o_rfValue,
    input  logic [REG_W-1:0]  i_qReg,
    output logic              o_qPending,
    output logic [DATA_W-1:0] o_qValue
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = REG_W + DATA_W;

    logic [CW-1:0]       w_count;
    logic [EW-1:0]       w_head;
    logic [DEPTH-1:0]    w_entry_valid;
    logic [DEPTH*EW-1:0] w_entry_data;
    logic                w_accept;
    logic                w_push1;
    logic                w_push2;
    logic                w_pop;
    rf_write_t           w_head_ent;
    logic                w_q_pending;
    logic [DATA_W-1:0]   w_q_value;

    logic                r_rf_write;
    logic [REG_W-1:0]    r_rf_reg;
    logic [DATA_W-1:0]   r_rf_value;

    // Handshake: a pair is taken when i_wbValid && o_wbReady; ready only promises room for two.
    assign o_wbReady  = w_count <= CW'(DEPTH - 2);
    assign w_accept   = i_wbValid & o_wbReady;
    assign w_push1    = w_accept & i_wbWrite1 & (i_wbReg1 != REG_NONE);
    assign w_push2    = w_accept & i_wbWrite2 & (i_wbReg2 != REG_NONE);
    assign w_pop      = w_count != '0;
    assign w_head_ent = w_head;

    regwrite_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk        (i_clock),
        .i_rst        (i_reset),
        .i_push1      (w_push1),
        .i_push1_data ({i_wbReg1, i_wbValue1}),
        .i_push2      (w_push2),
        .i_push2_data ({i_wbReg2, i_wbValue2}),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_entry_valid(w_entry_valid),
        .o_entry_data (w_entry_data)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rf_write <= 1'b0;
            r_rf_reg   <= '0;
            r_rf_value <= '0;
        end else if (w_pop) begin
            r_rf_write <= 1'b1;
            r_rf_reg   <= w_head_ent.idx;
            r_rf_value <= w_head_ent.value;
        end else begin
            r_rf_write <= 1'b0;
        end
    end

    // Scan oldest (rf port) to youngest (queue tail); the last match overrides earlier ones.
    always_comb begin
        w_q_pending = 1'b0;
        w_q_value   = '0;
        if (i_qReg != REG_NONE) begin
            if (r_rf_write && (r_rf_reg == i_qReg)) begin
                w_q_pending = 1'b1;
                w_q_value   = r_rf_value;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (w_entry_valid[k] && (w_entry_data[k*EW+DATA_W +: REG_W] == i_qReg)) begin
                    w_q_pending = 1'b1;
                    w_q_value   = w_entry_data[k*EW +: DATA_W];
                end
            end
        end
    end

    assign o_rfWrite  = r_rf_write;
    assign o_rfReg    = r_rf_reg;
    assign o_rfValue  = r_rf_value;
    assign o_qPending = w_q_pending;
    assign o_qValue   = w_q_value;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Bench for regfile_write_sequencer: queue-based reference model, rf-port scoreboard, query checks.
module tb_regfile_write_sequencer;

    localparam int         DEPTH    = 4;
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic [3:0]  r;
        logic [31:0] v;
    } ent_t;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_wbValid = 1'b0;
    logic        i_wbWrite1 = 1'b0;
    logic        i_wbWrite2 = 1'b0;
    logic [3:0]  i_wbReg1 = '0;
    logic [3:0]  i_wbReg2 = '0;
    logic [3:0]  i_qReg = '0;
    logic [31:0] i_wbValue1 = '0;
    logic [31:0] i_wbValue2 = '0;
    logic        o_wbReady;
    logic        o_rfWrite;
    logic        o_qPending;
    logic [3:0]  o_rfReg;
    logic [31:0] o_rfValue;
    logic [31:0] o_qValue;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending writes in arrival order plus what the rf port should show.
    ent_t        mq[$];
    logic [35:0] exp_q[$];
    logic        m_rf_write = 1'b0;
    logic [3:0]  m_rf_reg = '0;
    logic [31:0] m_rf_val = '0;
    logic        m_acc;
    ent_t        m_e;
    logic        ready_low;

    regfile_write_sequencer #(.DEPTH(DEPTH)) dut (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_wbValid (i_wbValid),
        .o_wbReady (o_wbReady),
        .i_wbWrite1(i_wbWrite1),
        .i_wbReg1  (i_wbReg1),
        .i_wbValue1(i_wbValue1),
        .i_wbWrite2(i_wbWrite2),
        .i_wbReg2  (i_wbReg2),
        .i_wbValue2(i_wbValue2),
        .o_rfWrite (o_rfWrite),
        .o_rfReg   (o_rfReg),
        .o_rfValue (o_rfValue),
        .i_qReg    (i_qReg),
        .o_qPending(o_qPending),
        .o_qValue  (o_qValue)
    );

    // Clock and reset
    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model step: the rf port takes the oldest pending write, then an accepted pair appends.
    initial forever begin
        @(posedge i_clock or posedge i_reset);
        if (i_reset) begin
            mq.delete();
            exp_q.delete();
            m_rf_write = 1'b0;
            m_rf_reg   = '0;
            m_rf_val   = '0;
        end else begin
            m_acc = i_wbValid && (mq.size() <= DEPTH - 2);
            if (mq.size() > 0) begin
                m_e        = mq.pop_front();
                m_rf_write = 1'b1;
                m_rf_reg   = m_e.r;
                m_rf_val   = m_e.v;
                exp_q.push_back(m_e);
            end else begin
                m_rf_write = 1'b0;
            end
            if (m_acc && i_wbWrite1 && (i_wbReg1 != REG_NONE)) mq.push_back({i_wbReg1, i_wbValue1});
            if (m_acc && i_wbWrite2 && (i_wbReg2 != REG_NONE)) mq.push_back({i_wbReg2, i_wbValue2});
        end
    end

    // Monitor: compare the rf port and ready every cycle, pop the scoreboard on each rf write.
    initial forever begin
        @(negedge i_clock);
        if (!i_reset) begin
            check("wb_ready", 64'(o_wbReady), 64'(mq.size() <= DEPTH - 2));
            check("rf_write", 64'(o_rfWrite), 64'(m_rf_write));
            check("rf_port", 64'({o_rfReg, o_rfValue}), 64'({m_rf_reg, m_rf_val}));
            if (o_rfWrite) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rf_scoreboard: got write r%0d=%0h, expected none", o_rfReg, o_rfValue);
                end else begin
                    check("rf_scoreboard", 64'({o_rfReg, o_rfValue}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    function automatic logic [32:0] model_query(input logic [3:0] q);
        logic [32:0] res;
        res = '0;
        if (q != REG_NONE) begin
            if (m_rf_write && (m_rf_reg == q)) res = {1'b1, m_rf_val};
            foreach (mq[k]) if (mq[k].r == q) res = {1'b1, mq[k].v};
        end
        return res;
    endfunction

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 7) == 0) ? REG_NONE : 4'($urandom_range(0, 6));
    endfunction

    // Driver: apply one cycle of inputs at the falling edge, then check the combinational query.
    task automatic drive(input logic v, input logic w1, input logic [3:0] r1, input logic [31:0] d1,
                         input logic w2, input logic [3:0] r2, input logic [31:0] d2,
                         input logic [3:0] q);
        logic [32:0] e;
        @(negedge i_clock);
        i_wbValid  = v;
        i_wbWrite1 = w1;
        i_wbReg1   = r1;
        i_wbValue1 = d1;
        i_wbWrite2 = w2;
        i_wbReg2   = r2;
        i_wbValue2 = d2;
        i_qReg     = q;
        #1;
        e = model_query(q);
        check("q_pending", 64'(o_qPending), 64'(e[32]));
        check("q_value", 64'(o_qValue), 64'(e[31:0]));
    endtask

    // Not valid: the other wb inputs carry junk that must be ignored.
    task automatic idle(input logic [3:0] q);
        drive(1'b0, 1'($urandom_range(0, 1)), rnd_reg(), $urandom,
              1'($urandom_range(0, 1)), rnd_reg(), $urandom, q);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 3; i++) idle(rnd_reg());
    endtask

    initial begin
        #1 i_reset = 1'b1;
        repeat (3) @(negedge i_clock);
        #2 i_reset = 1'b0;

        // Reset, then idle
        for (int i = 0; i < 10; i++) begin
            idle(4'($urandom_range(0, 14)));
            check("idle_rf_write", 64'(o_rfWrite), 64'd0);
            check("idle_ready", 64'(o_wbReady), 64'd1);
            check("idle_q_pending", 64'(o_qPending), 64'd0);
        end

        // Single write: visible on the rf port only after the second edge
        drive(1'b1, 1'b1, 4'd2, 32'h11, 1'b0, 4'd0, 32'h0, 4'd2);
        idle(4'd2);
        check("single_edge_n", 64'(o_rfWrite), 64'd0);
        idle(4'd2);
        check("single_edge_n1", 64'({o_rfWrite, o_rfReg, o_rfValue}), 64'({1'b1, 4'd2, 32'h11}));
        idle(4'd2);
        check("single_edge_n2", 64'(o_rfWrite), 64'd0);
        drain();

        // Back-to-back pairs
        ready_low = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 4'd6, 32'h100, 1'b1, 4'd3, 32'hAB, 4'($urandom_range(0, 6)));
            if (!o_wbReady) ready_low = 1'b1;
        end
        check("pair_ready_dropped", 64'(ready_low), 64'd1);
        drain();

        // Same register twice in one pair: write2 is the youngest
        drive(1'b1, 1'b1, 4'd1, 32'd5, 1'b1, 4'd1, 32'd9, 4'd1);
        idle(4'd1);
        check("same_q_both", 64'({o_qPending, o_qValue}), 64'({1'b1, 32'd9}));
        idle(4'd1);
        check("same_rf_first", 64'({o_rfWrite, o_rfReg, o_rfValue}), 64'({1'b1, 4'd1, 32'd5}));
        check("same_q_after_first", 64'({o_qPending, o_qValue}), 64'({1'b1, 32'd9}));
        idle(4'd1);
        check("same_rf_second", 64'({o_rfWrite, o_rfReg, o_rfValue}), 64'({1'b1, 4'd1, 32'd9}));
        drain();

        // REG_NONE is dropped
        drive(1'b1, 1'b1, 4'd15, 32'hDEAD, 1'b1, 4'd0, 32'd7, 4'd15);
        idle(4'd15);
        check("none_q15", 64'(o_qPending), 64'd0);
        idle(4'd0);
        check("none_rf_r0", 64'({o_rfWrite, o_rfReg, o_rfValue}), 64'({1'b1, 4'd0, 32'd7}));
        idle(4'd0);
        check("none_only_one", 64'(o_rfWrite), 64'd0);
        drain();

        // Reset with three entries queued
        drive(1'b1, 1'b1, 4'd6, 32'h66, 1'b1, 4'd3, 32'h33, 4'd3);
        drive(1'b1, 1'b1, 4'd5, 32'h55, 1'b1, 4'd4, 32'h44, 4'd3);
        @(negedge i_clock);
        i_wbValid = 1'b0;
        check("burst_ready_low", 64'(o_wbReady), 64'd0);
        #2 i_reset = 1'b1;
        #1;
        check("rst_rf_write", 64'(o_rfWrite), 64'd0);
        check("rst_ready", 64'(o_wbReady), 64'd1);
        i_qReg = 4'd4;
        #1;
        check("rst_q_pending", 64'(o_qPending), 64'd0);
        @(negedge i_clock);
        #2 i_reset = 1'b0;
        idle(4'd4);
        check("post_rst_rf_write", 64'(o_rfWrite), 64'd0);
        check("post_rst_q", 64'(o_qPending), 64'd0);

        // Random mixed traffic, enough to wrap the pointers many times
        for (int i = 0; i < 16 * DEPTH; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), rnd_reg(), $urandom,
                  1'($urandom_range(0, 1)), rnd_reg(), $urandom,
                  rnd_reg());
        end
        drain();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL timeout: simulation did not finish, limit 200000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
